// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the FIR MAC controller.
//   - state_t   : controller FSM states
//   - ADDR_W    : buffer / coefficient address width (64 taps max)
//   - ACC_W     : accumulator width for the default DW/CW (16+16+6)
//   - round_sat : round-half-up by 'frac' bits, then clamp to a signed 'dw'-bit range
package fir_pkg;

  localparam int DW_DEF   = 16;
  localparam int CW_DEF   = 16;
  localparam int FRAC_DEF = 15;
  localparam int ADDR_W   = 6;
  localparam int ACC_W    = DW_DEF + CW_DEF + 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  // Works on a 64-bit sign-extended accumulator so one function serves any
  // accumulator width up to 64 bits; callers truncate the clamped result.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input int frac,
                                                   input int dw);
    logic signed [63:0] rnd;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    rnd = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    hi  = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (dw - 1));
    if (rnd > hi) begin
      return hi;
    end else if (rnd < lo) begin
      return lo;
    end
    return rnd;
  endfunction

endpackage

// File: rtl/fir_coef_rf.sv
// fir_coef_rf: 2^AW x CW coefficient register file.
//   clk, rstn : clock, asynchronous active-low clear of every entry
//   we, waddr, wdata : synchronous write port (caller gates 'we')
//   raddr, rdata     : combinational read port
module fir_coef_rf #(
  parameter int CW = 16,
  parameter int AW = 6
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic signed [CW-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic signed [CW-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  logic signed [CW-1:0] rd_arr [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
      logic signed [CW-1:0] ent_q;
      logic signed [CW-1:0] ent_d;

      always_comb begin
        ent_d = ent_q;
        if (we && (waddr == AW'(gi))) begin
          ent_d = wdata;
        end
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          ent_q <= '0;
        end else begin
          ent_q <= ent_d;
        end
      end

      assign rd_arr[gi] = ent_q;
    end
  endgenerate

  assign rdata = rd_arr[raddr];

endmodule

// File: rtl/fir_mac_ctrl.sv
// fir_mac_ctrl: reader-side controller for the FIR sample shift buffer.
//   in_valid/in_ready/in_data    : one signed sample per handshake
//   out_valid/out_ready/out_data : one rounded, saturated result per sample
//   coef_we/coef_addr/coef_wdata : coefficient writes, honoured only when idle
//                                  and not accepting a sample
//   busy                         : high in every state except IDLE
//   buf_cen_n/buf_ren/buf_a/buf_d: shift-buffer command pins
//   buf_q                        : buffer data, valid the cycle after a read
module fir_mac_ctrl
  import fir_pkg::*;
#(
  parameter int NTAPS = 64,
  parameter int DW    = DW_DEF,
  parameter int CW    = CW_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DW-1:0]         in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         out_data,
  input  logic                  coef_we,
  input  logic [ADDR_W-1:0]     coef_addr,
  input  logic [CW-1:0]         coef_wdata,
  output logic                  busy,
  output logic                  buf_cen_n,
  output logic                  buf_ren,
  output logic [ADDR_W-1:0]     buf_a,
  output logic [DW-1:0]         buf_d,
  input  logic [DW-1:0]         buf_q
);

  // Accumulator grows by log2(64 taps) bits over the full product width.
  localparam int PW       = DW + CW;
  localparam int ACC_BITS = PW + ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(NTAPS - 1);

  state_t                     state_q, state_d;
  logic signed [DW-1:0]       sample_q, sample_d;
  logic signed [ACC_BITS-1:0] acc_q, acc_d;
  logic [ADDR_W-1:0]          tap_q, tap_d;
  logic [ADDR_W-1:0]          tap_dly_q, tap_dly_d;
  logic                       mac_vld_q, mac_vld_d;
  logic signed [DW-1:0]       out_data_q, out_data_d;

  logic                       coef_wr_en;
  logic signed [CW-1:0]       coef_rd;
  logic signed [PW-1:0]       prod;
  logic signed [ACC_BITS-1:0] mac_term;
  logic signed [ACC_BITS-1:0] acc_sum;

  // Coefficient is looked up by the delayed tap so it lines up with buf_q,
  // which the buffer returns one cycle after the read command.
  fir_coef_rf #(
    .CW (CW),
    .AW (ADDR_W)
  ) u_coef_rf (
    .clk   (clk),
    .rstn  (rstn),
    .we    (coef_wr_en),
    .waddr (coef_addr),
    .wdata ($signed(coef_wdata)),
    .raddr (tap_dly_q),
    .rdata (coef_rd)
  );

  assign prod     = $signed(buf_q) * coef_rd;
  assign mac_term = mac_vld_q ? ACC_BITS'(prod) : '0;
  assign acc_sum  = acc_q + mac_term;

  always_comb begin
    state_d    = state_q;
    sample_d   = sample_q;
    acc_d      = acc_q;
    tap_d      = tap_q;
    out_data_d = out_data_q;
    coef_wr_en = 1'b0;
    // A read issued this cycle produces a MAC next cycle.
    mac_vld_d  = (state_q == ST_READ);
    tap_dly_d  = tap_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sample_d = $signed(in_data);
          state_d  = ST_SHIFT;
        end else begin
          coef_wr_en = coef_we;
        end
      end
      ST_SHIFT: begin
        acc_d   = '0;
        tap_d   = '0;
        state_d = ST_READ;
      end
      ST_READ: begin
        acc_d = acc_sum;
        tap_d = tap_q + 1'b1;
        if (tap_q == LAST_TAP) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Final MAC folds straight into the rounded output.
        acc_d      = acc_sum;
        out_data_d = DW'(round_sat(64'(acc_sum), FRAC, DW));
        state_d    = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      sample_q   <= '0;
      acc_q      <= '0;
      tap_q      <= '0;
      tap_dly_q  <= '0;
      mac_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      sample_q   <= sample_d;
      acc_q      <= acc_d;
      tap_q      <= tap_d;
      tap_dly_q  <= tap_dly_d;
      mac_vld_q  <= mac_vld_d;
      out_data_q <= out_data_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_OUT);
  assign out_data  = out_data_q;

  assign buf_cen_n = !((state_q == ST_SHIFT) || (state_q == ST_READ));
  assign buf_ren   = (state_q == ST_SHIFT);
  assign buf_a     = (state_q == ST_READ) ? tap_q : '0;
  assign buf_d     = (state_q == ST_SHIFT) ? sample_q : '0;

endmodule

// File: tb/tb_fir_mac_ctrl.sv
module tb_fir_mac_ctrl;

  localparam int NTAPS = 64;
  localparam int DW    = 16;
  localparam int CW    = 16;
  localparam int FRAC  = 15;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_data = '0;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic                 coef_we = 1'b0;
  logic [5:0]           coef_addr = '0;
  logic signed [CW-1:0] coef_wdata = '0;
  logic                 busy;
  logic                 buf_cen_n;
  logic                 buf_ren;
  logic [5:0]           buf_a;
  logic signed [DW-1:0] buf_d;
  logic signed [DW-1:0] buf_q = '0;

  always #5 clk = ~clk;

  fir_mac_ctrl #(.NTAPS(NTAPS), .DW(DW), .CW(CW), .FRAC(FRAC)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .busy       (busy),
    .buf_cen_n  (buf_cen_n),
    .buf_ren    (buf_ren),
    .buf_a      (buf_a),
    .buf_d      (buf_d),
    .buf_q      (buf_q)
  );

  // External shift buffer: shift puts the new sample at address 0,
  // read returns mem[addr] registered. Not touched by rstn.
  logic signed [DW-1:0] bmem [64];
  logic buf_clr = 1'b0;
  initial for (int k = 0; k < 64; k++) bmem[k] = '0;
  always @(posedge clk) begin
    if (buf_clr) begin
      for (int k = 0; k < 64; k++) bmem[k] <= '0;
    end else if (!buf_cen_n) begin
      if (buf_ren) begin
        for (int k = 63; k > 0; k--) bmem[k] <= bmem[k-1];
        bmem[0] <= buf_d;
      end else begin
        buf_q <= bmem[buf_a];
      end
    end
  end

  // Reference model: sample history (newest first) and coefficient table.
  longint hist   [64];
  longint coef_m [64];

  function automatic longint ref_out();
    longint sum, r, hi, lo;
    sum = 0;
    for (int k = 0; k < NTAPS; k++) sum += hist[k] * coef_m[k];
    r  = (sum + (longint'(1) << (FRAC - 1))) >>> FRAC;
    hi = (longint'(1) << (DW - 1)) - 1;
    lo = -(longint'(1) << (DW - 1));
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return r;
  endfunction

  typedef struct {
    longint val;
    int     edge_no;
  } exp_t;
  exp_t sbq[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_out    = 0;
  bit hold     = 1'b0;
  bit rand_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event (t=%0t)", name, $time);
  endtask

  // out_ready changes just after the rising edge so the monitor sees it settled.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = hold ? 1'b0 : (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Monitor: latency on out_valid rise, data on handshake.
  initial begin
    bit   prev_ov;
    exp_t e;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_ov = 1'b0;
      end else begin
        if (out_valid && !prev_ov) begin
          if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out_valid actual=1 required=0 (t=%0t)", $time);
          end else begin
            chk("latency", longint'(cyc - sbq[0].edge_no + 1), longint'(NTAPS + 3));
          end
        end
        if (out_valid && out_ready && sbq.size() > 0) begin
          e = sbq.pop_front();
          n_out++;
          $display("OUT #%0d data=%0d exp=%0d", n_out, out_data, e.val);
          chk("out_data", longint'(out_data), e.val);
        end
        prev_ov = out_valid;
      end
    end
  end

  task automatic send(input logic signed [DW-1:0] s, input bit we_too);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      timeout("send_in_ready");
      return;
    end
    in_valid = 1'b1;
    in_data  = s;
    if (we_too) begin
      coef_we    = 1'b1;
      coef_addr  = 6'd0;
      coef_wdata = 16'sh7FFF;
    end
    for (int k = 63; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = longint'(s);
    sbq.push_back('{ref_out(), cyc + 1});
    $display("IN  data=%0d exp=%0d", s, sbq[$].val);
    @(negedge clk);
    in_valid = 1'b0;
    coef_we  = 1'b0;
    in_data  = DW'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!(sbq.size() == 0 && in_ready) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!(sbq.size() == 0 && in_ready)) timeout("wait_idle");
  endtask

  task automatic write_coef(input int addr, input logic signed [CW-1:0] val);
    @(negedge clk);
    coef_we    = 1'b1;
    coef_addr  = 6'(addr);
    coef_wdata = val;
    @(negedge clk);
    coef_we = 1'b0;
    coef_m[addr] = longint'(val);
  endtask

  task automatic drop_write(input int addr, input logic signed [CW-1:0] val);
    @(negedge clk);
    coef_we    = 1'b1;
    coef_addr  = 6'(addr);
    coef_wdata = val;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    coef_we  = 1'b0;
    rstn     = 1'b0;
    buf_clr  = 1'b1;
    #1;
    chk("rst_in_ready",  longint'(in_ready),  1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_data",  longint'(out_data),  0);
    chk("rst_busy",      longint'(busy),      0);
    chk("rst_buf_cen_n", longint'(buf_cen_n), 1);
    chk("rst_buf_ren",   longint'(buf_ren),   0);
    chk("rst_buf_a",     longint'(buf_a),     0);
    chk("rst_buf_d",     longint'(buf_d),     0);
    sbq.delete();
    for (int k = 0; k < 64; k++) begin
      hist[k]   = 0;
      coef_m[k] = 0;
    end
    @(negedge clk);
    buf_clr = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int held;
    int nv;
    int n;

    for (int k = 0; k < 64; k++) begin
      hist[k]   = 0;
      coef_m[k] = 0;
    end
    do_reset();

    // Reset in the middle of READ abandons the sample.
    write_coef(0, 16'sh4000);
    send(16'sd1000, 1'b0);
    repeat (10) @(negedge clk);
    chk("busy_in_read", longint'(busy), 1);
    do_reset();
    nv = 0;
    repeat (100) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    chk("no_out_after_reset", longint'(nv), 0);

    // Impulse.
    write_coef(0, 16'sh4000);
    send(16'sd1000, 1'b0);
    wait_idle();

    // Delay line on a fresh buffer.
    do_reset();
    write_coef(3, 16'sh4000);
    send(16'sd100, 1'b0);
    send(16'sd200, 1'b0);
    send(16'sd300, 1'b0);
    send(16'sd400, 1'b0);
    wait_idle();

    // Saturation, positive then negative.
    do_reset();
    for (int k = 0; k < 64; k++) write_coef(k, 16'sh7FFF);
    for (int k = 0; k < 64; k++) send(16'sh7FFF, 1'b0);
    wait_idle();
    for (int k = 0; k < 64; k++) send(-16'sd32768, 1'b0);
    wait_idle();

    // Backpressure with dropped writes while busy and on an accepting cycle.
    do_reset();
    write_coef(0, 16'sh4000);
    hold = 1'b1;
    send(16'sd1000, 1'b0);
    repeat (5) @(negedge clk);
    drop_write(0, 16'sh7FFF);
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) timeout("wait_out_valid");
    held = int'(out_data);
    for (int k = 0; k < 10; k++) begin
      chk("hold_out_valid", longint'(out_valid), 1);
      chk("hold_out_data",  longint'(out_data), longint'(held));
      chk("hold_in_ready",  longint'(in_ready), 0);
      if (k == 4) drop_write(1, 16'sh7FFF);
      else @(negedge clk);
    end
    hold = 1'b0;
    wait_idle();
    send(16'sd1000, 1'b1);
    wait_idle();
    send(16'sd1000, 1'b0);
    wait_idle();

    // Randomized samples and coefficients with random output stalls.
    do_reset();
    rand_rdy = 1'b1;
    for (int k = 0; k < 64; k++) write_coef(k, CW'($urandom_range(0, 4095) - 2048));
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        wait_idle();
        write_coef($urandom_range(0, 63), CW'($urandom));
      end
      send(DW'($urandom), 1'b0);
    end
    wait_idle();
    rand_rdy = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
